// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: architectural flag register, branch condition evaluation,
// 2-bit saturating branch history table and saturating branch statistics.
//
// Ports:
//   iClk, iRst            clock (rising edge), asynchronous active-high reset
//   iFlagWe, i*Flag       load Z/N/V/C flags (forwarded to a same-cycle resolve)
//   iPredPC, oPredTaken   fetch-stage prediction lookup (combinational)
//   iResValid, iResPC     branch resolving in execute and its PC
//   iBranchOp, iUnsigned  branch condition and signed/unsigned compare select
//   iPredTakenE           prediction that travelled with the branch
//   iTarget, iFallThrough taken / not-taken next PCs
//   oBranchCmd            registered: resolved branch was taken
//   oMispredict           registered: flush and redirect
//   oRedirectPC           registered: correct next PC
//   oBranchCount          saturating count of resolved branches
//   oMispredictCount      saturating count of mispredicts
module branch_resolve_unit #(
    parameter int unsigned PC_WIDTH  = 16,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iFlagWe,
    input  logic                 iZeroFlag,
    input  logic                 iNegativeFlag,
    input  logic                 iOverflowFlag,
    input  logic                 iCarryFlag,
    input  logic [PC_WIDTH-1:0]  iPredPC,
    output logic                 oPredTaken,
    input  logic                 iResValid,
    input  logic [PC_WIDTH-1:0]  iResPC,
    input  logic [2:0]           iBranchOp,
    input  logic                 iUnsigned,
    input  logic                 iPredTakenE,
    input  logic [PC_WIDTH-1:0]  iTarget,
    input  logic [PC_WIDTH-1:0]  iFallThrough,
    output logic                 oBranchCmd,
    output logic                 oMispredict,
    output logic [PC_WIDTH-1:0]  oRedirectPC,
    output logic [CNT_WIDTH-1:0] oBranchCount,
    output logic [CNT_WIDTH-1:0] oMispredictCount
);

    localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        OP_NEQ   = 3'b000,
        OP_EQ    = 3'b001,
        OP_GT    = 3'b010,
        OP_LT    = 3'b011,
        OP_GTE   = 3'b100,
        OP_LTE   = 3'b101,
        OP_OVFL  = 3'b110,
        OP_UNCON = 3'b111
    } branch_op_e;

    logic flag_z, flag_n, flag_v, flag_c;
    logic eff_z, eff_n, eff_v, eff_c;
    logic sign_lt;
    logic cond_c;
    logic taken_c;
    logic mispredict_c;
    branch_op_e op;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_next;

    // High PC bits do not take part in BHT indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{iPredPC[PC_WIDTH-1:IDX_W], iResPC[PC_WIDTH-1:IDX_W]};

    assign op       = branch_op_e'(iBranchOp);
    assign pred_idx = iPredPC[IDX_W-1:0];
    assign res_idx  = iResPC[IDX_W-1:0];

    // Prediction read has no bypass from a same-cycle update.
    assign oPredTaken = bht[pred_idx][1];

    // Flags written this cycle are forwarded to a resolve in the same cycle.
    assign eff_z = iFlagWe ? iZeroFlag     : flag_z;
    assign eff_n = iFlagWe ? iNegativeFlag : flag_n;
    assign eff_v = iFlagWe ? iOverflowFlag : flag_v;
    assign eff_c = iFlagWe ? iCarryFlag    : flag_c;
    assign sign_lt = eff_n ^ eff_v;

    // Branch condition; carry set means no borrow for unsigned compares.
    always_comb begin
        cond_c = 1'b0;
        case (op)
            OP_NEQ:   cond_c = ~eff_z;
            OP_EQ:    cond_c = eff_z;
            OP_GT:    cond_c = iUnsigned ? (eff_c & ~eff_z) : (~eff_z & ~sign_lt);
            OP_LT:    cond_c = iUnsigned ? ~eff_c : sign_lt;
            OP_GTE:   cond_c = iUnsigned ? eff_c : ~sign_lt;
            OP_LTE:   cond_c = iUnsigned ? (~eff_c | eff_z) : (eff_z | sign_lt);
            OP_OVFL:  cond_c = eff_v;
            OP_UNCON: cond_c = 1'b1;
            default:  cond_c = 1'b0;
        endcase
    end

    assign taken_c      = iResValid & cond_c;
    assign mispredict_c = iResValid & (cond_c ^ iPredTakenE);

    // Saturating 2-bit counter step for the resolving entry.
    always_comb begin
        bht_cur  = bht[res_idx];
        bht_next = bht_cur;
        if (taken_c) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
        end
    end

    // Architectural flag register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            flag_c <= 1'b0;
        end else if (iFlagWe) begin
            flag_z <= iZeroFlag;
            flag_n <= iNegativeFlag;
            flag_v <= iOverflowFlag;
            flag_c <= iCarryFlag;
        end
    end

    // Branch history table; entries start weakly not-taken.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht[i] <= 2'b01;
            end
        end else if (iResValid) begin
            bht[res_idx] <= bht_next;
        end
    end

    // Resolve outputs; pulses drop whenever no branch resolves.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oBranchCmd  <= 1'b0;
            oMispredict <= 1'b0;
            oRedirectPC <= '0;
        end else begin
            oBranchCmd  <= taken_c;
            oMispredict <= mispredict_c;
            if (iResValid) begin
                oRedirectPC <= taken_c ? iTarget : iFallThrough;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oBranchCount     <= '0;
            oMispredictCount <= '0;
        end else begin
            if (iResValid && (oBranchCount != CNT_MAX)) begin
                oBranchCount <= oBranchCount + CNT_WIDTH'(1);
            end
            if (mispredict_c && (oMispredictCount != CNT_MAX)) begin
                oMispredictCount <= oMispredictCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_branch_resolve_unit;

    localparam int unsigned PW  = 16;
    localparam int unsigned BD  = 16;
    localparam int unsigned CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flag_we, zf, nf, vf, cf;
    logic [PW-1:0] pred_pc;
    logic          pred_taken;
    logic          res_valid;
    logic [PW-1:0] res_pc;
    logic [2:0]    branch_op;
    logic          is_unsigned;
    logic          pred_taken_e;
    logic [PW-1:0] target, fall_through;
    logic          branch_cmd, mispredict;
    logic [PW-1:0] redirect_pc;
    logic [CW-1:0] branch_count, mispredict_count;

    branch_resolve_unit #(.PC_WIDTH(PW), .BHT_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .iClk(clk), .iRst(rst), .iFlagWe(flag_we),
        .iZeroFlag(zf), .iNegativeFlag(nf), .iOverflowFlag(vf), .iCarryFlag(cf),
        .iPredPC(pred_pc), .oPredTaken(pred_taken),
        .iResValid(res_valid), .iResPC(res_pc), .iBranchOp(branch_op),
        .iUnsigned(is_unsigned), .iPredTakenE(pred_taken_e),
        .iTarget(target), .iFallThrough(fall_through),
        .oBranchCmd(branch_cmd), .oMispredict(mispredict), .oRedirectPC(redirect_pc),
        .oBranchCount(branch_count), .oMispredictCount(mispredict_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    bit m_z, m_n, m_v, m_c;
    int m_bht [BD];
    int m_branches, m_mispredicts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic bit model_cond(int op, bit u, bit z, bit n, bit v, bit c);
        bit less_s;
        less_s = n ^ v;
        case (op)
            0: return !z;
            1: return z;
            2: return u ? (c && !z) : (!z && !less_s);
            3: return u ? !c : less_s;
            4: return u ? c : !less_s;
            5: return u ? (!c || z) : (z || less_s);
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int sat(int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic model_reset();
        m_z = 0; m_n = 0; m_v = 0; m_c = 0;
        for (int i = 0; i < int'(BD); i++) m_bht[i] = 1;
        m_branches = 0;
        m_mispredicts = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_bcnt"}, 32'(branch_count), 32'(sat(m_branches)));
        check({tag, "_mcnt"}, 32'(mispredict_count), 32'(sat(m_mispredicts)));
    endtask

    // One clock: apply inputs, check prediction, clock, check registered results.
    task automatic drive_cycle(input bit fwe, input bit z, input bit n, input bit v, input bit c,
                               input logic [PW-1:0] ppc, input bit rv, input logic [PW-1:0] rpc,
                               input int op, input bit u, input bit pte,
                               input logic [PW-1:0] tgt, input logic [PW-1:0] ft);
        bit ez, en, ev, ec, t, m;
        int idx;
        logic [PW-1:0] exp_pc;
        flag_we = fwe; zf = z; nf = n; vf = v; cf = c;
        pred_pc = ppc; res_valid = rv; res_pc = rpc; branch_op = 3'(op);
        is_unsigned = u; pred_taken_e = pte; target = tgt; fall_through = ft;
        #1;
        check("pred", 32'(pred_taken), 32'(m_bht[int'(ppc) % BD] >= 2));
        ez = fwe ? z : m_z; en = fwe ? n : m_n; ev = fwe ? v : m_v; ec = fwe ? c : m_c;
        t = 0; m = 0; exp_pc = '0;
        if (rv) begin
            t = model_cond(op, u, ez, en, ev, ec);
            m = t ^ pte;
            idx = int'(rpc) % BD;
            m_bht[idx] = t ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                           : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            m_branches++;
            if (m) m_mispredicts++;
            exp_pc = t ? tgt : ft;
        end
        if (fwe) begin
            m_z = z; m_n = n; m_v = v; m_c = c;
        end
        @(posedge clk);
        #1;
        check("cmd", 32'(branch_cmd), 32'(t));
        check("mis", 32'(mispredict), 32'(m));
        if (rv) check("redirect", 32'(redirect_pc), 32'(exp_pc));
        check_counts("cnt");
    endtask

    task automatic idle_cycle(input logic [PW-1:0] ppc);
        drive_cycle(0, 0, 0, 0, 0, ppc, 0, '0, 0, 0, 0, '0, '0);
    endtask

    // Assert reset while a resolve is being presented; it must be dropped.
    task automatic reset_midstream();
        res_valid = 1'b1; branch_op = 3'd7; pred_taken_e = 1'b0;
        res_pc = 16'(($urandom % BD)); target = 16'h5555; flag_we = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_cmd", 32'(branch_cmd), 32'd0);
        check("rst_mis", 32'(mispredict), 32'd0);
        check("rst_pc", 32'(redirect_pc), 32'd0);
        model_reset();
        check_counts("rst");
        @(posedge clk);
        #1;
        check("rst_hold_cmd", 32'(branch_cmd), 32'd0);
        check("rst_hold_mis", 32'(mispredict), 32'd0);
        res_valid = 1'b0; flag_we = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flag_we = 0; zf = 0; nf = 0; vf = 0; cf = 0;
        pred_pc = '0; res_valid = 0; res_pc = '0; branch_op = '0;
        is_unsigned = 0; pred_taken_e = 0; target = '0; fall_through = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("reset_cmd", 32'(branch_cmd), 32'd0);
        check("reset_mis", 32'(mispredict), 32'd0);
        check("reset_pc", 32'(redirect_pc), 32'd0);
        check_counts("reset");
        for (int i = 0; i < int'(BD); i++) idle_cycle(16'(i));

        // Latch Z=0 N=1 V=1 C=0; signed LT is not taken, unsigned LT is taken.
        drive_cycle(1, 0, 1, 1, 0, 16'h0, 0, '0, 0, 0, 0, '0, '0);
        drive_cycle(0, 0, 0, 0, 0, 16'h0, 1, 16'h0020, 3, 0, 0, 16'h0100, 16'h0022);
        drive_cycle(0, 0, 0, 0, 0, 16'h0, 1, 16'h0021, 3, 1, 0, 16'h0200, 16'h0024);

        // Forwarded Z=1 makes EQ taken; the following EQ uses the updated register.
        drive_cycle(1, 1, 0, 0, 0, 16'h0, 1, 16'h0030, 1, 0, 1, 16'h0300, 16'h0032);
        drive_cycle(0, 0, 0, 0, 0, 16'h0, 1, 16'h0031, 1, 0, 1, 16'h0310, 16'h0034);

        // BHT training at 0x0013 watched through prediction of 0x0003.
        for (int i = 0; i < 3; i++)
            drive_cycle(0, 0, 0, 0, 0, 16'h0003, 1, 16'h0013, 7, 0, 1, 16'h0400, 16'h0014);
        drive_cycle(0, 0, 0, 0, 0, 16'h0003, 1, 16'h0013, 1, 0, 0, 16'h0400, 16'h0014);
        drive_cycle(1, 0, 0, 0, 0, 16'h0003, 1, 16'h0013, 1, 0, 0, 16'h0400, 16'h0014);
        idle_cycle(16'h0003);
        check("bht_entry3_weak_t", 32'(pred_taken), 32'd1);

        // Signed GT taken while predicted not-taken.
        drive_cycle(1, 0, 0, 0, 0, 16'h0, 1, 16'h0040, 2, 0, 0, 16'h1234, 16'h0042);
        idle_cycle(16'h0);

        // Counter saturation from a clean start.
        reset_midstream();
        for (int i = 0; i < 20; i++)
            drive_cycle(0, 0, 0, 0, 0, 16'(i), 1, 16'(i), 7, 0, 0, 16'(i + 100), 16'(i + 1));
        check("sat_bcnt", 32'(branch_count), 32'hF);
        check("sat_mcnt", 32'(mispredict_count), 32'hF);
        reset_midstream();
        idle_cycle(16'h0);

        // Randomized traffic in bursts separated by mid-stream resets.
        for (int b = 0; b < 12; b++) begin
            for (int k = 0; k < 30; k++) begin
                logic [PW-1:0] ppc, rpc;
                ppc = 16'($urandom);
                rpc = 16'($urandom_range(0, 47));
                if ($urandom % 4 == 0) rpc = ppc;
                drive_cycle(($urandom % 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                            1'($urandom), ppc, ($urandom % 10) < 7, rpc,
                            int'($urandom % 8), 1'($urandom), 1'($urandom),
                            16'($urandom), 16'($urandom));
            end
            reset_midstream();
        end
        for (int i = 0; i < int'(BD); i++) idle_cycle(16'(i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Bounded run time.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
